// File: rtl/ram_scheduler.sv
// Three-requester burst arbiter for a single-port RAM. Round-robin ordering
// with an age override, per-word acks and one-cycle read-return tracking.
module ram_scheduler #(
    parameter int unsigned AGE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [2:0]  we,
    input  logic [41:0] addr_in,
    input  logic [11:0] len_in,
    input  logic [29:0] wdata_in,
    output logic [2:0]  grant,
    output logic [2:0]  ack,
    output logic [2:0]  rvalid,
    output logic [9:0]  rdata,
    output logic [13:0] ram_addr,
    output logic [9:0]  ram_wdata,
    output logic        ram_read,
    output logic        ram_write,
    input  logic [9:0]  ram_rdata,
    output logic        busy,
    output logic [1:0]  owner
);

    // state | meaning
    // IDLE  | no owner; pick a winner when any request is pending
    // BURST | owner holds the RAM port, one word per cycle
    // DRAIN | grant released, final read word returns this cycle
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  own_q, last_owner, rd_owner, winner, cand;
    logic [3:0]  cnt_q, len_q;
    logic [13:0] base_q;
    logic        we_q, rd_pend, found, access, start;
    logic [3:0]  age [3];
    logic [9:0]  wdata_a [3];
    logic [13:0] addr_a [3];
    logic [3:0]  len_a [3];

    assign wdata_a[0] = wdata_in[9:0];
    assign wdata_a[1] = wdata_in[19:10];
    assign wdata_a[2] = wdata_in[29:20];
    assign addr_a[0]  = addr_in[13:0];
    assign addr_a[1]  = addr_in[27:14];
    assign addr_a[2]  = addr_in[41:28];
    assign len_a[0]   = len_in[3:0];
    assign len_a[1]   = len_in[7:4];
    assign len_a[2]   = len_in[11:8];

    // Aged requesters win by lowest index; otherwise walk round robin after last_owner.
    always_comb begin
        winner = 2'd0;
        found  = 1'b0;
        cand   = last_owner;
        for (int i = 0; i < 3; i++) begin
            if (!found && req[i] && age[i] >= 4'(AGE_LIMIT)) begin
                winner = 2'(i);
                found  = 1'b1;
            end
        end
        for (int k = 0; k < 3; k++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign start  = (state == IDLE) && (|req);
    assign access = (state == BURST) && req[own_q];

    always_comb begin
        state_nxt = state;
        grant     = 3'b000;
        ack       = 3'b000;
        ram_read  = 1'b0;
        ram_write = 1'b0;
        ram_addr  = 14'd0;
        ram_wdata = 10'd0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = BURST;
            end
            BURST: begin
                grant = 3'b001 << own_q;
                if (!access) begin
                    state_nxt = rd_pend ? DRAIN : IDLE;
                end else begin
                    ack       = grant;
                    ram_read  = ~we_q;
                    ram_write = we_q;
                    ram_addr  = base_q + 14'(cnt_q);
                    ram_wdata = wdata_a[own_q];
                    if (cnt_q == len_q) state_nxt = we_q ? IDLE : DRAIN;
                end
            end
            DRAIN: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rvalid = rd_pend ? (3'b001 << rd_owner) : 3'b000;
    assign rdata  = rd_pend ? ram_rdata : 10'd0;
    assign busy   = (state != IDLE);
    assign owner  = (state == BURST) ? own_q : 2'd3;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            own_q      <= 2'd0;
            last_owner <= 2'd2;
            rd_owner   <= 2'd0;
            rd_pend    <= 1'b0;
            cnt_q      <= 4'd0;
            len_q      <= 4'd0;
            base_q     <= 14'd0;
            we_q       <= 1'b0;
            for (int i = 0; i < 3; i++) age[i] <= 4'd0;
        end else begin
            state    <= state_nxt;
            rd_pend  <= ram_read;
            rd_owner <= own_q;
            if (start) begin
                own_q      <= winner;
                last_owner <= winner;
                we_q       <= we[winner];
                base_q     <= addr_a[winner];
                len_q      <= len_a[winner];
                cnt_q      <= 4'd0;
            end else if (access) begin
                cnt_q <= cnt_q + 4'd1;
            end
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || grant[i] || (start && winner == 2'(i)))
                    age[i] <= 4'd0;
                else if (age[i] != 4'd15)
                    age[i] <= age[i] + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ram_scheduler.sv
// Bench for ram_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_ram_scheduler;

    localparam int AGE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, we;
    logic [41:0] addr_in;
    logic [11:0] len_in;
    logic [29:0] wdata_in;
    logic [2:0]  grant, ack, rvalid;
    logic [9:0]  rdata, ram_wdata, ram_rdata;
    logic [13:0] ram_addr;
    logic        ram_read, ram_write, busy;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_errors = 0;

    // model state: phase 0 idle, 1 owning, 2 draining
    int ph, m_own, m_we, m_left, m_addr, m_last, m_rv;
    int m_age [3];

    ram_scheduler #(.AGE_LIMIT(AGE_LIMIT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr_in(addr_in),
        .len_in(len_in), .wdata_in(wdata_in), .grant(grant), .ack(ack),
        .rvalid(rvalid), .rdata(rdata), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_read(ram_read), .ram_write(ram_write),
        .ram_rdata(ram_rdata), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r);
        for (int i = 0; i < 3; i++)
            if (r[i] && m_age[i] >= AGE_LIMIT) return i;
        for (int k = 1; k <= 3; k++)
            if (r[(m_last + k) % 3]) return (m_last + k) % 3;
        return -1;
    endfunction

    task automatic model_reset();
        ph = 0; m_own = 0; m_we = 0; m_left = 0; m_addr = 0;
        m_last = 2; m_rv = -1;
        for (int i = 0; i < 3; i++) m_age[i] = 0;
    endtask

    // Called right after a falling edge with inputs set: check, advance model, wait.
    task automatic tick();
        int acc, e_rd, win, nrv;
        #4;
        acc  = (ph == 1 && req[m_own]) ? 1 : 0;
        e_rd = (acc != 0 && m_we == 0) ? 1 : 0;
        check("grant",  32'(grant),  (ph == 1) ? 32'(1 << m_own) : 32'd0);
        check("ack",    32'(ack),    acc != 0 ? 32'(1 << m_own) : 32'd0);
        check("ram_read",  32'(ram_read),  32'(e_rd));
        check("ram_write", 32'(ram_write), 32'(acc != 0 && m_we != 0));
        check("ram_addr",  32'(ram_addr),  acc != 0 ? 32'(m_addr) : 32'd0);
        check("ram_wdata", 32'(ram_wdata), acc != 0 ? 32'((wdata_in >> (10 * m_own)) & 30'h3FF) : 32'd0);
        check("rvalid", 32'(rvalid), m_rv >= 0 ? 32'(1 << m_rv) : 32'd0);
        check("rdata",  32'(rdata),  m_rv >= 0 ? 32'(ram_rdata) : 32'd0);
        check("busy",   32'(busy),   32'(ph != 0));
        check("owner",  32'(owner),  ph == 1 ? 32'(m_own) : 32'd3);
        if (rst) begin
            model_reset();
        end else begin
            nrv = e_rd != 0 ? m_own : -1;
            win = (ph == 0 && req != 3'b000) ? pick(req) : -1;
            for (int i = 0; i < 3; i++) begin
                if (!req[i] || (ph == 1 && i == m_own) || i == win) m_age[i] = 0;
                else if (m_age[i] < 15) m_age[i]++;
            end
            case (ph)
                0: if (win >= 0) begin
                    ph     = 1;
                    m_own  = win;
                    m_last = win;
                    m_we   = we[win];
                    m_addr = int'((addr_in >> (14 * win)) & 42'h3FFF);
                    m_left = int'((len_in >> (4 * win)) & 12'hF) + 1;
                end
                1: if (acc == 0) begin
                    ph = (m_rv >= 0) ? 2 : 0;
                end else begin
                    m_left--;
                    m_addr = (m_addr + 1) % 16384;
                    if (m_left == 0) ph = (m_we != 0) ? 0 : 2;
                end
                default: ph = 0;
            endcase
            m_rv = nrv;
        end
        @(negedge clk);
        wdata_in  = 30'($urandom);
        ram_rdata = 10'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst = 1'b1; req = 3'b000; we = 3'b000;
        addr_in = '0; len_in = '0; wdata_in = '0; ram_rdata = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        run(2);

        // 4-word read from 0x0100
        req = 3'b001; we = 3'b000; addr_in = 42'h100; len_in = 12'h003;
        run(5);
        req = 3'b000; run(3);

        // everyone asks for single-word writes
        req = 3'b111; we = 3'b111; len_in = 12'h000;
        run(9);
        req = 3'b000; run(2);

        // long bursts from 0 and 2 while 1 ages
        req = 3'b111; we = 3'b111; len_in = 12'hF0F;
        run(70);
        req = 3'b000; run(2);

        // write burst wrapping the top of the address space
        req = 3'b100; we = 3'b100; addr_in = {14'h3FFE, 28'd0}; len_in = 12'h300;
        run(5);
        req = 3'b000; run(2);

        // read len 8 aborted after the third word
        req = 3'b001; we = 3'b000; addr_in = 42'h2A0; len_in = 12'h007;
        run(4);
        req = 3'b000; run(3);

        // reset during the second word of a read
        req = 3'b001; we = 3'b000; len_in = 12'h007;
        run(2);
        rst = 1'b1; run(1);
        rst = 1'b0; req = 3'b000; run(3);

        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            we      = 3'($urandom);
            addr_in = {10'($urandom), 32'($urandom)};
            len_in  = ($urandom_range(0, 1) == 0) ? 12'($urandom) & 12'h333 : 12'($urandom);
            rst     = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0; req = 3'b000; run(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_scheduler.md
RAM_SCHEDULER -- requirements
Module: ram_scheduler

Interface
REQ-001 Parameter AGE_LIMIT, default 8: wait cycles (1..15) after which a pending requester overrides round-robin order.
REQ-002 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1: synchronous, active-high reset.
REQ-004 Port req  input  3: per-requester access request; bit 0 = DMA, bit 1 = cache fill, bit 2 = cache write-back.
REQ-005 Port we  input  3: per-requester direction; 1 = write burst, 0 = read burst.
REQ-006 Port addr_in  input  42: per-requester 14-bit base address, requester i in bits [14i+13:14i].
REQ-007 Port len_in  input  12: per-requester 4-bit burst length code, requester i in bits [4i+3:4i]; burst = code+1 words (1..16).
REQ-008 Port wdata_in  input  30: per-requester 10-bit write data, requester i in bits [10i+9:10i].
REQ-009 Port grant  output  3: one-hot ownership; at most one bit set.
REQ-010 Port ack  output  3: one-cycle pulse per word issued to RAM for the owner.
REQ-011 Port rvalid  output  3: one-cycle pulse per read word returned to the owner.
REQ-012 Port rdata  output  10: read data, valid only with an rvalid bit.
REQ-013 Port ram_addr / ram_wdata / ram_read / ram_write  output  14/10/1/1: shared RAM port.
REQ-014 Port ram_rdata  input  10: RAM read data, valid exactly one cycle after ram_read.
REQ-015 Port busy / owner  output  1/2: busy=1 in any non-IDLE state; owner = granted index, 3 when none.

Function
REQ-016 FSM states IDLE, BURST, DRAIN; 2-bit encoding.
REQ-017 IDLE: if any req bit set, latch winner's we, base addr, len; next cycle BURST with grant[winner]=1; word counter = 0.
REQ-018 Winner: lowest-index requester whose age counter >= AGE_LIMIT; otherwise round robin starting at (last_owner+1) mod 3.
REQ-019 Round-robin pointer last_owner updates when a grant is issued.
REQ-020 Age counter per requester: +1 each cycle req=1 and not granted, saturates at 15, clears on grant or when req=0.
REQ-021 BURST: every cycle issue one access: ram_addr = base + counter (mod 2^14, wrap 16383->0), ram_read=~we or ram_write=we, ack[owner]=1.
REQ-022 ram_wdata = wdata_in of owner, combinational; requester advances data after each ack.
REQ-023 ram_read and ram_write never high together; both 0 outside BURST.
REQ-024 Read latency: rvalid[owner]=1 and rdata=ram_rdata exactly one cycle after each ram_read.
REQ-025 After last word (counter = len): read burst -> DRAIN; write burst -> IDLE; grant clears same edge.
REQ-026 DRAIN lasts one cycle (delivers final rvalid), then IDLE; no new grant in DRAIN.
REQ-027 Abort: req[owner]=0 in BURST -> no access that cycle, grant clears next edge, go DRAIN if prior cycle was a read issue, else IDLE.
REQ-028 Non-owner req changes during BURST/DRAIN only affect age counters.
REQ-029 Owner's addr_in/len_in/we changes during BURST are ignored (latched at grant).
REQ-030 Minimum gap between bursts: one IDLE cycle (write) or DRAIN+IDLE (read).

Reset
REQ-031 On rst=1 at a clock edge: state IDLE, grant/ack/rvalid=0, ram_read/ram_write=0, rdata=0, busy=0, owner=3, counters and age counters 0, last_owner=2 (requester 0 first).
REQ-032 Reset mid-burst abandons the burst; no rvalid is produced for a read issued in the reset cycle.

Verification
REQ-033 req=001, we=0, addr0=0x0100, len0=3 -> grant=001 one cycle later; ram_addr 0x0100..0x0103 on 4 consecutive cycles with ack[0]; rvalid[0] 4 pulses delayed by one cycle; busy falls after DRAIN.
REQ-034 req=111 all idle from reset -> grants in order 0,1,2 each one word (len=0, writes); owner sequence 0,1,2.
REQ-035 Requester 1 held behind continuous 16-word bursts of 0 and 2 with AGE_LIMIT=8 -> requester 1 granted at next IDLE once age >= 8, ahead of round robin.
REQ-036 Write burst addr2=0x3FFE, len2=3, we=1 -> ram_addr 0x3FFE, 0x3FFF, 0x0000, 0x0001 with ram_write=1 and ram_wdata = wdata_in[29:20] each cycle.
REQ-037 Read burst len=7, req dropped after 3rd ack -> 3 accesses, 3 rvalid pulses, DRAIN then IDLE.
REQ-038 rst=1 during 2nd word of a read burst -> next cycle all outputs at reset values, owner=3, no further rvalid.
